// File: rtl/riscv_proc_lwb_pkg.sv
// Shared definitions for the long-latency writeback queue: tag width,
// result source encoding and the pointer-width helper.
package riscv_proc_lwb_pkg;

  localparam int TAG_W = 5;

  typedef enum logic {
    SRC_DIV = 1'b0,
    SRC_MUL = 1'b1
  } lwb_src_e;

  function automatic int lwb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/riscv_proc_lwb_fifo.sv
// Two-write, one-read circular buffer of {tag, data} entries with occupancy count.
// Writes must be compacted: wr1 is only meaningful when wr0 is also asserted.
module riscv_proc_lwb_fifo
  import riscv_proc_lwb_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = lwb_ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr0_en_i,
  input  logic [TAG_W-1:0] wr0_tag_i,
  input  logic [W-1:0]     wr0_data_i,
  input  logic             wr1_en_i,
  input  logic [TAG_W-1:0] wr1_tag_i,
  input  logic [W-1:0]     wr1_data_i,
  input  logic             rd_en_i,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [W-1:0]     rd_data_o,
  output logic [PW:0]      count_o
);

  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [W-1:0]     data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] tail_p1;
  logic [PW:0]   count_q, count_d;

  assign tail_p1 = tail_q + PW'(1);

  always_comb begin
    head_d  = head_q + PW'(rd_en_i);
    tail_d  = tail_q + PW'(wr0_en_i) + PW'(wr1_en_i);
    count_d = count_q + (PW+1)'(wr0_en_i) + (PW+1)'(wr1_en_i) - (PW+1)'(rd_en_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; an empty queue never exposes it.
  always_ff @(posedge clk_i) begin
    if (wr0_en_i) begin
      tag_q[tail_q]  <= wr0_tag_i;
      data_q[tail_q] <= wr0_data_i;
    end
    if (wr1_en_i) begin
      tag_q[tail_p1]  <= wr1_tag_i;
      data_q[tail_p1] <= wr1_data_i;
    end
  end

  assign rd_tag_o  = tag_q[head_q];
  assign rd_data_o = data_q[head_q];
  assign count_o   = count_q;

endmodule

// File: rtl/riscv_proc_lwb_queue.sv
// Long-latency writeback queue between div/mul result pulses and the regfile port.
// Optional same-cycle bypass when empty: define RISCV_LWB_BYPASS_EN.
module riscv_proc_lwb_queue
  import riscv_proc_lwb_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_result_val,
  input  logic [TAG_W-1:0] div_result_tag,
  input  logic [W-1:0]     div_result_bits,
  input  logic             mul_result_val,
  input  logic [TAG_W-1:0] mul_result_tag,
  input  logic [W-1:0]     mul_result_bits,
  input  logic             wb_free,
  output logic             lwb_val,
  output logic [TAG_W-1:0] lwb_waddr,
  output logic [W-1:0]     lwb_wdata,
  output logic             lwb_rdy,
  output logic             lwb_overflow
);

  localparam int PW = lwb_ptr_w(DEPTH);

  logic             div_ok, mul_ok;
  logic             req_div, req_mul;
  logic             empty, deq;
  logic             byp_val;
  logic [TAG_W-1:0] byp_tag;
  logic [W-1:0]     byp_data;
  logic [PW:0]      count, space;
  logic             acc0, acc1, drop;
  lwb_src_e         slot0_src;
  logic [TAG_W-1:0] wr0_tag, head_tag;
  logic [W-1:0]     wr0_data, head_data;
  logic             ovf_q, ovf_d;

  // Tag 0 is x0: such results are dropped silently and never count as overflow.
  assign div_ok = div_result_val && (div_result_tag != '0);
  assign mul_ok = mul_result_val && (mul_result_tag != '0);

  assign empty = (count == '0);
  assign deq   = reset && !empty && wb_free;

`ifdef RISCV_LWB_BYPASS_EN
  assign byp_val  = reset && empty && wb_free && (div_ok || mul_ok);
  assign byp_tag  = div_ok ? div_result_tag  : mul_result_tag;
  assign byp_data = div_ok ? div_result_bits : mul_result_bits;
  assign req_div  = div_ok && !byp_val;
  assign req_mul  = mul_ok && !(byp_val && !div_ok);
`else
  assign byp_val  = 1'b0;
  assign byp_tag  = '0;
  assign byp_data = '0;
  assign req_div  = div_ok;
  assign req_mul  = mul_ok;
`endif

  // A dequeue in the same cycle frees a slot for an incoming result.
  assign space = (PW+1)'(DEPTH) - count + (PW+1)'(deq);

  always_comb begin
    acc0      = 1'b0;
    acc1      = 1'b0;
    drop      = 1'b0;
    slot0_src = req_div ? SRC_DIV : SRC_MUL;
    if (space >= (PW+1)'(2)) begin
      acc0 = req_div || req_mul;
      acc1 = req_div && req_mul;
    end else if (space == (PW+1)'(1)) begin
      acc0 = req_div || req_mul;
      drop = req_div && req_mul;
    end else begin
      drop = req_div || req_mul;
    end
  end

  assign wr0_tag  = (slot0_src == SRC_DIV) ? div_result_tag  : mul_result_tag;
  assign wr0_data = (slot0_src == SRC_DIV) ? div_result_bits : mul_result_bits;

  riscv_proc_lwb_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .wr0_en_i   (acc0),
    .wr0_tag_i  (wr0_tag),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (acc1),
    .wr1_tag_i  (mul_result_tag),
    .wr1_data_i (mul_result_bits),
    .rd_en_i    (deq),
    .rd_tag_o   (head_tag),
    .rd_data_o  (head_data),
    .count_o    (count)
  );

  assign ovf_d = ovf_q || drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign lwb_val      = deq || byp_val;
  assign lwb_waddr    = byp_val ? byp_tag  : (empty ? '0 : head_tag);
  assign lwb_wdata    = byp_val ? byp_data : (empty ? '0 : head_data);
  assign lwb_rdy      = (((PW+1)'(DEPTH) - count) >= (PW+1)'(2));
  assign lwb_overflow = ovf_q;

endmodule

// File: doc/riscv_proc_lwb_queue.md
# riscv_proc_lwb_queue

Long-latency writeback queue sitting directly downstream of the processor divider and multiplier. It captures their fire-and-forget result pulses (valid/tag/bits, no back-pressure), buffers them in a small FIFO, and writes them into the register file only in cycles where the main pipeline leaves the writeback port free. It also tells issue logic when a new long-latency operation may be launched without risking loss of a result.

## Interface
- W, 64, datapath width; even, ≥ 8
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 clears the queue immediately
- div_result_val  input  1  divider result pulse, one cycle
- div_result_tag  input  5  destination register
- div_result_bits  input  W  result data
- mul_result_val  input  1  multiplier result pulse, one cycle
- mul_result_tag  input  5  destination register
- mul_result_bits  input  W  result data
- wb_free  input  1  pipeline does not use the regfile write port this cycle
- lwb_val  output  1  regfile write enable (long-latency port)
- lwb_waddr  output  5  regfile write address
- lwb_wdata  output  W  regfile write data
- lwb_rdy  output  1  ≥ 2 free entries; issue may launch a div/mul
- lwb_overflow  output  1  sticky: a result was dropped for lack of space

## Operation
- Storage: circular FIFO of DEPTH entries {tag, data}; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Filter: any result with tag 0 is discarded, never enqueued, and never counts toward overflow.
- Enqueue: up to two per cycle. If both valid the same cycle, div is written at tail, mul at tail+1.
- Dequeue: lwb_val = (count != 0) && wb_free; lwb_waddr/lwb_wdata = head entry. Head advances on the clock edge when lwb_val is high. At most one dequeue per cycle.
- Capacity rule: accepted entries per cycle = min(requests, DEPTH − count + deq), where deq is this cycle's dequeue. Full plus simultaneous dequeue admits one entry.
- Overflow: when requests exceed capacity, the mul result is dropped first, then the div result. lwb_overflow sets and stays 1 until reset.
- lwb_rdy = (DEPTH − count) ≥ 2, registered view of current count. Issue logic must gate div_val/mul issue on it.
- Ordering: results retire strictly in acceptance order. Two results to the same tag retire in order, so the later one wins.
- Reset (any time, including mid-burst): head = tail = count = 0, lwb_overflow = 0, and entries are discarded. lwb_val = 0 and lwb_rdy = 1 while reset is low, plus lwb_waddr = 0 and lwb_wdata = 0 when empty.

## Timing
- Without bypass: a result accepted at edge N is visible at head from cycle N+1. Minimum writeback latency is 1 cycle after the pulse.
- A result that waits behind k entries retires at the earliest k+1 wb_free cycles after acceptance.
- No combinational path from the div/mul inputs to lwb_* except under the bypass feature.
- wb_free low stalls the head indefinitely. No entry is ever lost while capacity allows.

## Configuration
- RISCV_LWB_BYPASS_EN defined:
  - When count == 0 and wb_free is high, the highest-priority non-zero-tag incoming result (div before mul) drives lwb_* in the same cycle and is not enqueued.
  - The other incoming result, if any, is enqueued.
  - This adds a combinational input-to-output path.
- Undefined: all results pass through the FIFO, with 1-cycle minimum latency.

## Structure
- Shared package/header: tag width (5), the source-priority encoding (DIV=0, MUL=1), and a helper for the pointer width, log2(DEPTH).
- One sub-module, riscv_proc_lwb_fifo: a two-write, one-read circular buffer with count, parameterised by W and DEPTH.
- The top level holds the tag-0 filter, the capacity/drop logic, overflow, bypass and the lwb_rdy generation.

## Test plan
- Single div pulse, tag 7, data 0x1234, wb_free=1 → lwb_val one cycle later with waddr 7, wdata 0x1234. With bypass: same cycle, and count stays 0.
- div (tag 3, 0xA) and mul (tag 4, 0xB) in the same cycle, wb_free=1 → two writes on consecutive cycles: first 3/0xA, then 4/0xB.
- wb_free held 0 and 4 results with tags 1..4 → count=4, lwb_rdy=0 after the 3rd. Then wb_free=1 → tags retire 1,2,3,4 in order, and lwb_rdy returns to 1 when count ≤ 2.
- Queue full, wb_free=1, div+mul both arriving → div accepted, mul dropped, lwb_overflow=1 sticky. Count remains 4.
- A result with tag 0 while empty → no lwb_val, count unchanged, no overflow.
- reset pulled low while count=3 and wb_free=1 → lwb_val drops immediately. After release: count=0, lwb_rdy=1, lwb_overflow=0, and no stale entries are written.
